pong_sound_engine: RTL

- Audio stage that sits directly downstream of the game logic and takes over the buzzer output from the top level.
- Converts game events into timed square-wave tone sequences on a single buzzer pin. The events are the bounce code and changes in either player's score.
- Replaces the fixed-length single-tone buzzer counter with per-event pitch and duration, a two-note score jingle, and priority arbitration.

---
 rtl/pong_sound_engine_if.sv | 26 ++
 rtl/pong_sound_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pong_sound_engine_if.sv
// Signal bundle between the game logic and the sound engine.
//   bounce    : game-logic bounce code (0 none, 1 paddle, 2 wall, 3 ignored)
//   score_one : player one score
//   score_two : player two score
//   mute      : 1 forces the buzzer low, sequencing continues
//   buzzer    : registered square-wave drive
//   busy      : 1 while any tone sequence (including the score gap) is active
// master = game-logic side, slave = sound engine side.
interface pong_sound_engine_if;
  logic [1:0] bounce;
  logic [3:0] score_one;
  logic [3:0] score_two;
  logic       mute;
  logic       buzzer;
  logic       busy;

  modport master (
    output bounce, score_one, score_two, mute,
    input  buzzer, busy
  );

  modport slave (
    input  bounce, score_one, score_two, mute,
    output buzzer, busy
  );
endinterface

// File: rtl/pong_sound_engine.sv
// Pong sound engine: turns bounce codes and score changes into timed
// square-wave tone sequences on a single buzzer pin.
//   clk   : system clock
//   reset : asynchronous, active-low
//   sif   : pong_sound_engine_if.slave (bounce, score_one, score_two, mute in;
//           buzzer, busy out)
// Events: score change to a non-zero value (priority 3), bounce edge to paddle
// (2), bounce edge to wall (1). An event with priority >= the active one
// restarts the sequence; lower ones are dropped.
// Optional macro PONG_SOUND_QUEUE_EN: keeps the most recent dropped event in a
// one-entry slot and plays it once the engine returns to idle.
module pong_sound_engine #(
  parameter int unsigned PADDLE_HALF  = 6000,
  parameter int unsigned WALL_HALF    = 12000,
  parameter int unsigned SCORE_HALF_A = 9000,
  parameter int unsigned SCORE_HALF_B = 18000,
  parameter int unsigned TONE_LEN     = 600000,
  parameter int unsigned GAP_LEN      = 240000,
  parameter int unsigned SCORE_LEN    = 1800000,
  parameter int unsigned HALF_W       = 16,
  parameter int unsigned LEN_W        = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  pong_sound_engine_if.slave   sif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TONE,
    ST_GAP,
    ST_NOTE_B
  } state_e;

  localparam logic [1:0] PRI_NONE   = 2'd0;
  localparam logic [1:0] PRI_WALL   = 2'd1;
  localparam logic [1:0] PRI_PADDLE = 2'd2;
  localparam logic [1:0] PRI_SCORE  = 2'd3;

  localparam logic [HALF_W-1:0] PADDLE_HM1  = HALF_W'(PADDLE_HALF - 1);
  localparam logic [HALF_W-1:0] WALL_HM1    = HALF_W'(WALL_HALF - 1);
  localparam logic [HALF_W-1:0] SCORE_A_HM1 = HALF_W'(SCORE_HALF_A - 1);
  localparam logic [HALF_W-1:0] SCORE_B_HM1 = HALF_W'(SCORE_HALF_B - 1);
  localparam logic [LEN_W-1:0]  TONE_LM1    = LEN_W'(TONE_LEN - 1);
  localparam logic [LEN_W-1:0]  GAP_LM1     = LEN_W'(GAP_LEN - 1);
  localparam logic [LEN_W-1:0]  SCORE_LM1   = LEN_W'(SCORE_LEN - 1);

  state_e            state_q, state_d;
  logic [1:0]        cur_pri_q, cur_pri_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              tone_q, tone_d;
  logic              buzzer_q, buzzer_d;
  logic [1:0]        ev_pri_q, ev_pri_d;
  logic [1:0]        bounce_prev_q;
  logic [3:0]        score_one_prev_q, score_two_prev_q;
  logic [HALF_W-1:0] half_lim;
  logic [LEN_W-1:0]  len_lim;
  logic [1:0]        start_pri;
`ifdef PONG_SOUND_QUEUE_EN
  logic [1:0]        pend_q, pend_d;
`endif

  // Score history is sampled on every clock, including while reset is low,
  // so scores held through reset never look like a change on release.
  always_ff @(posedge clk) begin
    score_one_prev_q <= sif.score_one;
    score_two_prev_q <= sif.score_two;
  end

  // Event detect; only the highest-priority event of a cycle survives.
  always_comb begin
    ev_pri_d = PRI_NONE;
    if ((sif.score_one != score_one_prev_q && sif.score_one != '0) ||
        (sif.score_two != score_two_prev_q && sif.score_two != '0)) begin
      ev_pri_d = PRI_SCORE;
    end else if (sif.bounce == 2'd1 && bounce_prev_q != 2'd1) begin
      ev_pri_d = PRI_PADDLE;
    end else if (sif.bounce == 2'd2 && bounce_prev_q != 2'd2) begin
      ev_pri_d = PRI_WALL;
    end
  end

  // Half-period and duration limits follow from state and active priority.
  always_comb begin
    half_lim = WALL_HM1;
    if (state_q == ST_NOTE_B)          half_lim = SCORE_B_HM1;
    else if (cur_pri_q == PRI_SCORE)   half_lim = SCORE_A_HM1;
    else if (cur_pri_q == PRI_PADDLE)  half_lim = PADDLE_HM1;

    len_lim = TONE_LM1;
    if (state_q == ST_NOTE_B)          len_lim = SCORE_LM1;
    else if (state_q == ST_GAP)        len_lim = GAP_LM1;
  end

  always_comb begin
    state_d   = state_q;
    cur_pri_d = cur_pri_q;
    half_d    = half_q;
    len_d     = len_q;
    tone_d    = tone_q;
    start_pri = PRI_NONE;
`ifdef PONG_SOUND_QUEUE_EN
    pend_d    = pend_q;
`endif

    case (state_q)
      ST_TONE, ST_NOTE_B: begin
        if (half_q == half_lim) begin
          half_d = '0;
          tone_d = ~tone_q;
        end else begin
          half_d = half_q + 1'b1;
        end
        len_d = len_q + 1'b1;
        if (len_q == len_lim) begin
          half_d = '0;
          len_d  = '0;
          tone_d = 1'b0;
          if (state_q == ST_TONE && cur_pri_q == PRI_SCORE) begin
            state_d = ST_GAP;
          end else begin
            state_d   = ST_IDLE;
            cur_pri_d = PRI_NONE;
          end
        end
      end
      ST_GAP: begin
        tone_d = 1'b0;
        len_d  = len_q + 1'b1;
        if (len_q == len_lim) begin
          len_d   = '0;
          state_d = ST_NOTE_B;
        end
      end
      default: begin
        tone_d = 1'b0;
      end
    endcase

    // cur_pri is 0 in idle, so any event starts from idle.
    if (ev_pri_q != PRI_NONE && ev_pri_q >= cur_pri_q) begin
      start_pri = ev_pri_q;
`ifdef PONG_SOUND_QUEUE_EN
      if (ev_pri_q >= pend_q) pend_d = PRI_NONE;
    end else if (ev_pri_q != PRI_NONE) begin
      pend_d = ev_pri_q;
    end else if (state_q == ST_IDLE && pend_q != PRI_NONE) begin
      start_pri = pend_q;
      pend_d    = PRI_NONE;
`endif
    end

    // A (re)start overrides the normal progression of this cycle.
    if (start_pri != PRI_NONE) begin
      state_d   = ST_TONE;
      cur_pri_d = start_pri;
      half_d    = '0;
      len_d     = '0;
      tone_d    = 1'b0;
    end

    buzzer_d = tone_d & ~sif.mute;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cur_pri_q     <= PRI_NONE;
      half_q        <= '0;
      len_q         <= '0;
      tone_q        <= 1'b0;
      buzzer_q      <= 1'b0;
      ev_pri_q      <= PRI_NONE;
      bounce_prev_q <= '0;
`ifdef PONG_SOUND_QUEUE_EN
      pend_q        <= PRI_NONE;
`endif
    end else begin
      state_q       <= state_d;
      cur_pri_q     <= cur_pri_d;
      half_q        <= half_d;
      len_q         <= len_d;
      tone_q        <= tone_d;
      buzzer_q      <= buzzer_d;
      ev_pri_q      <= ev_pri_d;
      bounce_prev_q <= sif.bounce;
`ifdef PONG_SOUND_QUEUE_EN
      pend_q        <= pend_d;
`endif
    end
  end

  assign sif.buzzer = buzzer_q;
  assign sif.busy   = (state_q != ST_IDLE);

endmodule
